// File: rtl/usb_ft245_if.sv
// usb_ft245_if
// Bridge between a local command/data path and an FTDI FT245 parallel USB FIFO.
// Bytes from the PC are read one at a time into CMD_BYTE. 16-bit words from
// the local side are written to the PC as two bytes, low byte first.
//
// Ports
//   CLK        system clock (125 MHz)
//   RST        synchronous active-high reset
//   RXF, TXE   FT245 FIFO flags, asynchronous, active low
//   USBX_I     bus read data
//   USBX_O     bus drive data
//   USBX_OE    bus drive enable (tristate control at the top level)
//   RD         read strobe, active low
//   WR         write strobe, byte latched by the FT245 on the falling edge
//   CMD_BYTE   last byte received
//   CMD_VALID  one-cycle pulse when CMD_BYTE updates
//   TX_WORD    word to send
//   TX_VALID   TX_WORD is valid
//   TX_READY   word accepted this cycle when TX_VALID is also high
//   RX_COUNT   received byte count, wraps at 256
//   BUSY       FSM is not idle
module usb_ft245_if #(
  parameter int RD_LOW_CYC  = 5,
  parameter int RD_GAP_CYC  = 2,
  parameter int WR_HIGH_CYC = 5,
  parameter int WR_LOW_CYC  = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXF,
  input  logic        TXE,
  input  logic [7:0]  USBX_I,
  output logic [7:0]  USBX_O,
  output logic        USBX_OE,
  output logic        RD,
  output logic        WR,
  output logic [7:0]  CMD_BYTE,
  output logic        CMD_VALID,
  input  logic [15:0] TX_WORD,
  input  logic        TX_VALID,
  output logic        TX_READY,
  output logic [7:0]  RX_COUNT,
  output logic        BUSY
);

  // Counters hold "remaining cycles minus one", so a phase ends when the counter reaches zero.
  localparam logic [3:0] RD_LOW_LD  = 4'(RD_LOW_CYC - 1);
  localparam logic [3:0] RD_GAP_LD  = 4'(RD_GAP_CYC - 1);
  localparam logic [3:0] WR_HIGH_LD = 4'(WR_HIGH_CYC - 1);
  localparam logic [3:0] WR_LOW_LD  = 4'(WR_LOW_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_LOW    = 3'd1,
    ST_RD_GAP    = 3'd2,
    ST_TX_LO_SET = 3'd3,
    ST_TX_LO_END = 3'd4,
    ST_TX_HI_SET = 3'd5,
    ST_TX_HI_END = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [15:0] tx_word_r;
  logic        rxf_meta_r, rxf_s_r, txe_meta_r, txe_s_r;
  logic        accept_s;
  logic        rd_r, wr_r, oe_r, cmd_valid_r, busy_r;
  logic [7:0]  usbx_o_r, cmd_byte_r, rx_count_r;
  logic        rd_s, wr_s, oe_s, cmd_valid_s, busy_s;
  logic [7:0]  usbx_o_s;
  logic        tx_set_s, tx_any_s, tx_hi_s;

  assign RD        = rd_r;
  assign WR        = wr_r;
  assign USBX_OE   = oe_r;
  assign USBX_O    = usbx_o_r;
  assign CMD_BYTE  = cmd_byte_r;
  assign CMD_VALID = cmd_valid_r;
  assign RX_COUNT  = rx_count_r;
  assign BUSY      = busy_r;

  // Reads win: the handshake is only offered while no byte is waiting from the PC.
  assign TX_READY = (state_r == ST_IDLE) && rxf_s_r && !RST;
  assign accept_s = TX_VALID && TX_READY;

  // Two-flop synchronizers for the asynchronous FIFO flags (idle high).
  always_ff @(posedge CLK) begin
    if (RST) begin
      rxf_meta_r <= 1'b1;
      rxf_s_r    <= 1'b1;
      txe_meta_r <= 1'b1;
      txe_s_r    <= 1'b1;
    end else begin
      rxf_meta_r <= RXF;
      rxf_s_r    <= rxf_meta_r;
      txe_meta_r <= TXE;
      txe_s_r    <= txe_meta_r;
    end
  end

  // State register, phase counter and captured transmit word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      tx_word_r <= 16'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        tx_word_r <= TX_WORD;
      end
    end
  end

  // Next-state and counter reload logic.
  // In the *_SET states the registered WR tells the waiting phase (WR=0, waiting
  // for TXE) apart from the drive phase (WR=1, counting down WR_HIGH_CYC).
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!rxf_s_r) begin
          state_s = ST_RD_LOW;
          cnt_s   = RD_LOW_LD;
        end else if (accept_s) begin
          state_s = ST_TX_LO_SET;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_LOW: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RD_GAP;
          cnt_s   = RD_GAP_LD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RD_GAP: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_TX_LO_SET, ST_TX_HI_SET: begin
        if (!wr_r) begin
          if (!txe_s_r) begin
            cnt_s = WR_HIGH_LD;
          end else begin
            cnt_s = cnt_r;
          end
        end else if (cnt_r == 4'd0) begin
          state_s = (state_r == ST_TX_LO_SET) ? ST_TX_LO_END : ST_TX_HI_END;
          cnt_s   = WR_LOW_LD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_TX_LO_END: begin
        if (cnt_r == 4'd0) begin
          // Loaded for the case where WR rises on entry (TXE already low).
          state_s = ST_TX_HI_SET;
          cnt_s   = WR_HIGH_LD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_TX_HI_END: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  // WR may not rise on the very first TX_LO_SET cycle because the word is
  // captured on that same edge; from TX_LO_END it may rise on entry so that
  // the low time between the two bytes is exactly WR_LOW_CYC.
  always_comb begin
    tx_set_s    = (state_s == ST_TX_LO_SET) || (state_s == ST_TX_HI_SET);
    tx_hi_s     = (state_s == ST_TX_HI_SET) || (state_s == ST_TX_HI_END);
    tx_any_s    = tx_set_s || (state_s == ST_TX_LO_END) || (state_s == ST_TX_HI_END);
    rd_s        = (state_s != ST_RD_LOW);
    busy_s      = (state_s != ST_IDLE);
    cmd_valid_s = (state_r == ST_RD_LOW) && (state_s == ST_RD_GAP);
    if (tx_set_s && (state_r != ST_IDLE)) begin
      wr_s = wr_r || !txe_s_r;
    end else begin
      wr_s = 1'b0;
    end
    // Once WR has risen for the word the bus stays driven until IDLE.
    oe_s = tx_any_s && (wr_s || oe_r);
    if (oe_s) begin
      usbx_o_s = tx_hi_s ? tx_word_r[15:8] : tx_word_r[7:0];
    end else begin
      usbx_o_s = 8'd0;
    end
  end

  // Output registers, received byte capture and receive counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_r        <= 1'b1;
      wr_r        <= 1'b0;
      oe_r        <= 1'b0;
      usbx_o_r    <= 8'd0;
      busy_r      <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_byte_r  <= 8'd0;
      rx_count_r  <= 8'd0;
    end else begin
      rd_r        <= rd_s;
      wr_r        <= wr_s;
      oe_r        <= oe_s;
      usbx_o_r    <= usbx_o_s;
      busy_r      <= busy_s;
      cmd_valid_r <= cmd_valid_s;
      if (cmd_valid_s) begin
        cmd_byte_r <= USBX_I;
        rx_count_r <= rx_count_r + 8'd1;
      end else begin
        cmd_byte_r <= cmd_byte_r;
        rx_count_r <= rx_count_r;
      end
    end
  end

endmodule

// File: tb/tb_usb_ft245_if.sv
// tb_usb_ft245_if
// Directed stimulus for usb_ft245_if. Expected read results and written
// bytes are queued when stimulus is issued; a negedge monitor pops and
// compares them whenever the DUT shows a CMD_VALID pulse, an RD rise, a WR
// fall or the end of a WR low phase.
module tb_usb_ft245_if;

  logic        CLK = 1'b0;
  logic        RST, RXF, TXE, TX_VALID;
  logic [7:0]  USBX_I;
  logic [15:0] TX_WORD;
  logic [7:0]  USBX_O, CMD_BYTE, RX_COUNT;
  logic        USBX_OE, RD, WR, CMD_VALID, TX_READY, BUSY;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_rx[$];   // {CMD_BYTE, RX_COUNT}
  int          exp_rdl[$];  // RD low length
  logic [15:0] exp_wrb[$];  // {byte, WR high length}
  int          exp_wrl[$];  // WR low length while driving
  logic [7:0]  rx_model = 8'd0;
  int          cmd_pulses = 0;

  usb_ft245_if dut (
    .CLK(CLK), .RST(RST), .RXF(RXF), .TXE(TXE),
    .USBX_I(USBX_I), .USBX_O(USBX_O), .USBX_OE(USBX_OE),
    .RD(RD), .WR(WR), .CMD_BYTE(CMD_BYTE), .CMD_VALID(CMD_VALID),
    .TX_WORD(TX_WORD), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_COUNT(RX_COUNT), .BUSY(BUSY)
  );

  always #4 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return RD;
      1: return WR;
      2: return TX_READY;
      3: return BUSY;
      default: return 1'b0;
    endcase
  endfunction

  // Poll on negedges until the selected signal equals val; cycles = negedges waited.
  task automatic wait_for(input int which, input logic val, input string name, output int cycles);
    logic cur;
    cycles = 0;
    cur = sel(which);
    while (cur !== val && cycles < 3000) begin
      @(negedge CLK);
      cycles++;
      cur = sel(which);
    end
    if (cur !== val) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: got %0b want %0b", name, cur, val);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input int hi_len, input int lo_gap, input int end_gap);
    exp_wrb.push_back({w[7:0], 8'd5});
    exp_wrb.push_back({w[15:8], 8'(hi_len)});
    exp_wrl.push_back(lo_gap);
    exp_wrl.push_back(end_gap);
  endtask

  task automatic push_read(input logic [7:0] d);
    rx_model = rx_model + 8'd1;
    exp_rx.push_back({d, rx_model});
    exp_rdl.push_back(5);
  endtask

  // Offer a word and hold TX_VALID until the handshake edge.
  task automatic handshake(input logic [15:0] w);
    int c;
    TX_WORD  = w;
    TX_VALID = 1'b1;
    wait_for(2, 1'b1, "tx_ready", c);
    @(negedge CLK);
    TX_VALID = 1'b0;
  endtask

  // Monitor state
  logic       wr_prev = 1'b0, rd_prev = 1'b1, cv_prev = 1'b0, in_low = 1'b0;
  int         hi_cnt = 0, low_cnt = 0, rd_cnt = 0;
  logic [7:0] byte_cap = 8'd0;

  always @(negedge CLK) begin
    check("rd_wr_overlap", 32'(!RD && WR), 32'd0);
    check("oe_during_rd", 32'(!RD && USBX_OE), 32'd0);
    // read strobe length
    if (!RD) begin
      rd_cnt++;
    end else if (!rd_prev) begin
      if (exp_rdl.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_low_len", 32'(rd_cnt), 32'(exp_rdl.pop_front()));
      rd_cnt = 0;
    end
    // received bytes
    if (CMD_VALID) begin
      cmd_pulses++;
      check("cmd_single_cycle", 32'(cv_prev), 32'd0);
      if (exp_rx.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
      else check("cmd_byte_count", 32'({CMD_BYTE, RX_COUNT}), 32'(exp_rx.pop_front()));
    end
    // written bytes
    if (WR) begin
      if (!wr_prev) begin
        if (in_low) begin
          if (exp_wrl.size() == 0) check("wr_low_unexpected", 32'd1, 32'd0);
          else check("wr_low_len", 32'(low_cnt), 32'(exp_wrl.pop_front()));
          in_low = 1'b0;
        end
        hi_cnt = 1;
      end else begin
        hi_cnt++;
      end
      byte_cap = USBX_O;
    end else begin
      if (wr_prev) begin
        if (exp_wrb.size() == 0) check("wr_byte_unexpected", 32'd1, 32'd0);
        else check("wr_byte_len", 32'({byte_cap, 8'(hi_cnt)}), 32'(exp_wrb.pop_front()));
        in_low  = 1'b1;
        low_cnt = 0;
      end
      if (in_low) begin
        if (USBX_OE) begin
          low_cnt++;
        end else begin
          if (exp_wrl.size() == 0) check("wr_low_unexpected", 32'd1, 32'd0);
          else check("wr_low_len", 32'(low_cnt), 32'(exp_wrl.pop_front()));
          in_low = 1'b0;
        end
      end
    end
    wr_prev = WR;
    rd_prev = RD;
    cv_prev = CMD_VALID;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    RST = 1'b1; RXF = 1'b1; TXE = 1'b1; USBX_I = 8'h00;
    TX_WORD = 16'h0000; TX_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_rd", 32'(RD), 32'd1);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_oe", 32'(USBX_OE), 32'd0);
    check("rst_usbx_o", 32'(USBX_O), 32'd0);
    check("rst_cmd", 32'({CMD_BYTE, CMD_VALID}), 32'd0);
    check("rst_rx_count", 32'(RX_COUNT), 32'd0);
    check("rst_tx_ready", 32'(TX_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    TX_VALID = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // single read of 0x05
    USBX_I = 8'h05;
    push_read(8'h05);
    RXF = 1'b0;
    wait_for(0, 1'b0, "rd_fall", c);
    check("rd_latency", 32'(c), 32'd3);
    RXF = 1'b1;
    wait_for(0, 1'b1, "rd_rise", c);
    check("rd_low_cycles", 32'(c), 32'd5);
    wait_for(3, 1'b0, "rd_gap", c);
    check("rd_gap_cycles", 32'(c), 32'd2);
    check("cmd_byte_0x05", 32'(CMD_BYTE), 32'h05);
    check("rx_count_1", 32'(RX_COUNT), 32'd1);

    // word 0xA55A with TXE low
    TXE = 1'b0;
    repeat (3) @(negedge CLK);
    push_word(16'hA55A, 5, 7, 7);
    handshake(16'hA55A);
    wait_for(3, 1'b0, "word_a55a_done", c);
    check("oe_after_word", 32'(USBX_OE), 32'd0);

    // read and word requested together: read first, word after the gap
    USBX_I = 8'h7E;
    push_read(8'h7E);
    push_word(16'h1234, 5, 7, 7);
    TX_WORD = 16'h1234;
    RXF = 1'b0;
    repeat (2) @(negedge CLK);
    TX_VALID = 1'b1;
    check("prio_ready_low", 32'(TX_READY), 32'd0);
    wait_for(0, 1'b0, "prio_rd_fall", c);
    RXF = 1'b1;
    wait_for(0, 1'b1, "prio_rd_rise", c);
    wait_for(2, 1'b1, "prio_accept", c);
    check("accept_after_gap", 32'(c), 32'd2);
    @(negedge CLK);
    TX_VALID = 1'b0;
    wait_for(3, 1'b0, "word_1234_done", c);

    // TXE goes high after the low byte: stall in TX_HI_SET
    push_word(16'hBEEF, 5, 18, 7);
    handshake(16'hBEEF);
    wait_for(1, 1'b1, "stall_wr_rise", c);
    wait_for(1, 1'b0, "stall_wr_fall", c);
    TXE = 1'b1;
    repeat (8) @(negedge CLK);
    check("stall_wr_low", 32'(WR), 32'd0);
    check("stall_oe_high", 32'(USBX_OE), 32'd1);
    check("stall_busy", 32'(BUSY), 32'd1);
    repeat (7) @(negedge CLK);
    TXE = 1'b0;
    wait_for(3, 1'b0, "word_beef_done", c);

    // reset during the high byte WR-high phase
    push_word(16'hC3D2, 1, 7, 0);
    handshake(16'hC3D2);
    wait_for(1, 1'b1, "abort_rise_lo", c);
    wait_for(1, 1'b0, "abort_fall_lo", c);
    wait_for(1, 1'b1, "abort_rise_hi", c);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_wr", 32'(WR), 32'd0);
    check("abort_oe", 32'(USBX_OE), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_usbx_o", 32'(USBX_O), 32'd0);
    check("abort_rx_count", 32'(RX_COUNT), 32'd0);
    RST = 1'b0;
    rx_model = 8'd0;
    repeat (2) @(negedge CLK);

    // fresh word after the abort
    push_word(16'h0FF0, 5, 7, 7);
    handshake(16'h0FF0);
    wait_for(3, 1'b0, "word_0ff0_done", c);

    // 257 back-to-back reads: count wraps to 1
    USBX_I = 8'h3C;
    for (int i = 0; i < 257; i++) push_read(8'h3C);
    RXF = 1'b0;
    for (int i = 0; i < 257; i++) begin
      wait_for(0, 1'b0, "burst_rd_fall", c);
      if (i == 256) RXF = 1'b1;
      wait_for(0, 1'b1, "burst_rd_rise", c);
    end
    wait_for(3, 1'b0, "burst_done", c);
    check("rx_count_wrap", 32'(RX_COUNT), 32'd1);
    check("cmd_pulse_total", 32'(cmd_pulses), 32'd259);

    repeat (5) @(negedge CLK);
    check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    check("rdl_queue_empty", 32'(exp_rdl.size()), 32'd0);
    check("wrb_queue_empty", 32'(exp_wrb.size()), 32'd0);
    check("wrl_queue_empty", 32'(exp_wrl.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
